// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4-to-1 mux: walks the enabled channels, dwells on each,
// samples the mux output and publishes a 4-bit result word with valid/ack.
module mux_scan_ctrl #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic [3:0] ch_mask,
  input  logic       mux_out,
  output logic [1:0] select,
  output logic [3:0] result,
  output logic       result_valid,
  input  logic       result_ack,
  output logic       busy,
  output logic       overrun
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    select_reg, select_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    mask_reg, mask_next;
  logic [3:0]    shadow_reg, shadow_next;
  logic [3:0]    result_reg, result_next;
  logic          valid_reg, valid_next;
  logic          overrun_reg, overrun_next;
  logic [2:0]    adv;

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    lowest_ch = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) lowest_ch = 2'(i);
  endfunction

  // {found, channel} of the lowest enabled channel strictly above cur
  function automatic logic [2:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
    next_ch = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (m[i] && (i > int'(cur))) next_ch = {1'b1, 2'(i)};
  endfunction

  assign adv = next_ch(mask_reg, select_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      select_reg  <= 2'd0;
      cnt_reg     <= '0;
      mask_reg    <= 4'd0;
      shadow_reg  <= 4'd0;
      result_reg  <= 4'd0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      select_reg  <= select_next;
      cnt_reg     <= cnt_next;
      mask_reg    <= mask_next;
      shadow_reg  <= shadow_next;
      result_reg  <= result_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    select_next  = select_reg;
    cnt_next     = cnt_reg;
    mask_next    = mask_reg;
    shadow_next  = shadow_reg;
    result_next  = result_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;

    if (valid_reg && result_ack) begin
      valid_next   = 1'b0;
      overrun_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (start && (ch_mask != 4'd0)) begin
          mask_next   = ch_mask;
          select_next = lowest_ch(ch_mask);
          cnt_next    = CNT_INIT;
          state_next  = SCAN;
        end
      end
      SCAN: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else begin
          shadow_next[select_reg] = mux_out;
          if (adv[2]) begin
            select_next = adv[1:0];
            cnt_next    = CNT_INIT;
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        // A load coinciding with an ack wins: valid stays set, no overrun.
        result_next = shadow_reg & mask_reg;
        valid_next  = 1'b1;
        if (valid_reg && !result_ack) overrun_next = 1'b1;
        if (continuous && (ch_mask != 4'd0)) begin
          mask_next   = ch_mask;
          select_next = lowest_ch(ch_mask);
          cnt_next    = CNT_INIT;
          state_next  = SCAN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign select       = select_reg;
  assign result       = result_reg;
  assign result_valid = valid_reg;
  assign overrun      = overrun_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: behavioural 4-to-1 mux on select, expected words
// queued at scan start and compared when result_valid shows a new word.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [3:0] ch_mask = 4'd0;
  logic       mux_out;
  logic [1:0] select;
  logic [3:0] result;
  logic       result_valid;
  logic       result_ack = 1'b0;
  logic       busy;
  logic       overrun;
  logic [3:0] in_vec = 4'd0;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;
  assign mux_out = in_vec[select];

  mux_scan_ctrl #(.DWELL(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .ch_mask(ch_mask), .mux_out(mux_out), .select(select), .result(result),
    .result_valid(result_valid), .result_ack(result_ack), .busy(busy),
    .overrun(overrun)
  );

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic start_scan(input logic [3:0] m);
    ch_mask = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int rise);
    rise = -1;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      if (result_valid) begin
        rise = t;
        break;
      end
    end
  endtask

  task automatic ack_cycle();
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++; if (select !== 2'd0) begin miscompares++; $display("FAIL reset_select got %0d want 0", select); end
    vectors++; if (result !== 4'd0) begin miscompares++; $display("FAIL reset_result got %b want 0000", result); end
    vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", result_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", overrun); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_scan();
    int rise;
    logic [3:0] exp;
    in_vec = 4'b0010;
    exp_q.push_back(in_vec & 4'b1111);
    start_scan(4'b1111);
    rise = -1;
    for (int t = 0; t <= 20; t++) begin
      if (t > 0) @(negedge clk);
      if (t < 8) begin
        vectors++;
        if (select !== 2'(t / 2)) begin miscompares++; $display("FAIL full_select t=%0d got %0d want %0d", t, select, t / 2); end
      end
      if (result_valid) begin rise = t; break; end
    end
    vectors++; if (rise !== 9) begin miscompares++; $display("FAIL full_latency got %0d want 9", rise); end
    exp = exp_q.pop_front();
    vectors++; if (result !== exp) begin miscompares++; $display("FAIL full_result got %b want %b", result, exp); end
    vectors++; if (busy !== 1'b0 || select !== 2'd3) begin miscompares++; $display("FAIL full_idle busy=%b select=%0d want busy=0 select=3", busy, select); end
    ack_cycle();
    vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL full_ack got %b want 0", result_valid); end
    $display("full_scan: result=%b latency=%0d", result, rise);
  endtask

  task automatic test_sparse();
    int rise;
    logic [3:0] exp;
    in_vec = 4'b1111;
    exp_q.push_back(in_vec & 4'b1010);
    start_scan(4'b1010);
    rise = -1;
    for (int t = 0; t <= 20; t++) begin
      if (t > 0) @(negedge clk);
      if (t < 4) begin
        vectors++;
        if (select !== ((t < 2) ? 2'd1 : 2'd3)) begin miscompares++; $display("FAIL sparse_select t=%0d got %0d", t, select); end
      end
      if (result_valid) begin rise = t; break; end
    end
    vectors++; if (rise !== 5) begin miscompares++; $display("FAIL sparse_latency got %0d want 5", rise); end
    exp = exp_q.pop_front();
    vectors++; if (result !== exp) begin miscompares++; $display("FAIL sparse_result got %b want %b", result, exp); end
    ack_cycle();
    $display("sparse_scan: result=%b latency=%0d", exp, rise);
  endtask

  task automatic test_continuous();
    int rise;
    logic [3:0] exp;
    continuous = 1'b1;
    in_vec = 4'b1010;
    exp_q.push_back(in_vec);
    start_scan(4'b1111);
    wait_valid(rise);
    vectors++; if (rise !== 9) begin miscompares++; $display("FAIL cont_latency got %0d want 9", rise); end
    exp = exp_q.pop_front();
    vectors++; if (result !== exp || overrun !== 1'b0) begin miscompares++; $display("FAIL cont_first result=%b overrun=%b want %b/0", result, overrun, exp); end
    in_vec = 4'b1011;
    exp_q.push_back(in_vec);
    for (int t = 10; t <= 18; t++) begin
      @(negedge clk);
      if (t == 10) continuous = 1'b0;
      if (t == 17) begin
        vectors++;
        if (result !== 4'b1010 || overrun !== 1'b0 || result_valid !== 1'b1) begin miscompares++; $display("FAIL cont_hold result=%b overrun=%b valid=%b", result, overrun, result_valid); end
      end
    end
    exp = exp_q.pop_front();
    vectors++; if (result !== exp) begin miscompares++; $display("FAIL cont_second got %b want %b", result, exp); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL cont_overrun got %b want 1", overrun); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cont_stop busy got %b want 0", busy); end
    ack_cycle();
    vectors++; if (result_valid !== 1'b0 || overrun !== 1'b0) begin miscompares++; $display("FAIL cont_ack valid=%b overrun=%b want 0/0", result_valid, overrun); end
    $display("continuous: second result=%b", exp);
  endtask

  task automatic test_ignored();
    int rise;
    logic [3:0] exp;
    start_scan(4'b0000);
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || result_valid !== 1'b0) begin miscompares++; $display("FAIL mask0 t=%0d busy=%b valid=%b want 0/0", t, busy, result_valid); end
    end
    in_vec = 4'b0101;
    exp_q.push_back(in_vec & 4'b1111);
    start_scan(4'b1111);
    rise = -1;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (t == 3) begin start = 1'b1; ch_mask = 4'b0011; end
      if (t == 4) start = 1'b0;
      if (result_valid) begin rise = t; break; end
    end
    vectors++; if (rise !== 9) begin miscompares++; $display("FAIL busy_start latency got %0d want 9", rise); end
    exp = exp_q.pop_front();
    vectors++; if (result !== exp) begin miscompares++; $display("FAIL busy_start result got %b want %b", result, exp); end
    ack_cycle();
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || result_valid !== 1'b0) begin miscompares++; $display("FAIL busy_start extra t=%0d busy=%b valid=%b", t, busy, result_valid); end
    end
    $display("ignored_starts: result=%b", exp);
  endtask

  task automatic test_reset_mid();
    int rise;
    logic [3:0] exp;
    in_vec = 4'b0000;
    start_scan(4'b1111);
    for (int t = 1; t <= 4; t++) @(negedge clk);
    vectors++; if (select !== 2'd2) begin miscompares++; $display("FAIL midreset_pre select got %0d want 2", select); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({select, result, result_valid, busy, overrun} !== 9'd0) begin
      miscompares++;
      $display("FAIL midreset_async sel=%0d res=%b valid=%b busy=%b ovr=%b want all 0", select, result, result_valid, busy, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_vec = 4'b1110;
    exp_q.push_back(in_vec & 4'b1111);
    start_scan(4'b1111);
    wait_valid(rise);
    vectors++; if (rise !== 9) begin miscompares++; $display("FAIL midreset_latency got %0d want 9", rise); end
    exp = exp_q.pop_front();
    vectors++; if (result !== exp) begin miscompares++; $display("FAIL midreset_result got %b want %b", result, exp); end
    ack_cycle();
    $display("reset_mid_scan: result=%b", exp);
  endtask

  task automatic test_ack_collision();
    int rise;
    logic [3:0] exp;
    continuous = 1'b1;
    in_vec = 4'b0001;
    exp_q.push_back(in_vec & 4'b0011);
    start_scan(4'b0011);
    wait_valid(rise);
    vectors++; if (rise !== 5) begin miscompares++; $display("FAIL collide_latency got %0d want 5", rise); end
    exp = exp_q.pop_front();
    vectors++; if (result !== exp) begin miscompares++; $display("FAIL collide_first got %b want %b", result, exp); end
    in_vec = 4'b0010;
    exp_q.push_back(in_vec & 4'b0011);
    for (int t = 6; t <= 9; t++) @(negedge clk);
    result_ack = 1'b1;
    continuous = 1'b0;
    @(negedge clk);
    result_ack = 1'b0;
    exp = exp_q.pop_front();
    vectors++; if (result_valid !== 1'b1) begin miscompares++; $display("FAIL collide_valid got %b want 1", result_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL collide_overrun got %b want 0", overrun); end
    vectors++; if (result !== exp) begin miscompares++; $display("FAIL collide_result got %b want %b", result, exp); end
    ack_cycle();
    $display("ack_collision: result=%b", exp);
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_sparse();
    test_continuous();
    test_ignored();
    test_reset_mid();
    test_ack_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
